// File: rtl/rf_pkt_pkg.sv
// Shared types and constants for the OOK RF packet transmitter.
package rf_pkt_pkg;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [63:0] SYNC_MASK = 64'h7C00_001F_0000_0000;
  localparam int unsigned PKT_BYTES = 8;

  function automatic logic sync_ok(input logic [63:0] pkt);
    return (pkt & SYNC_MASK) == SYNC_MASK;
  endfunction

endpackage

// File: rtl/rf_bit_timer.sv
// Bit-period counter: free-runs while enabled and produces the pulse window
// and the end-of-period strobe. It holds at zero while disabled.
module rf_bit_timer #(
  parameter int unsigned BIT_PERIOD   = 10000,
  parameter int unsigned PULSE_OFFSET = 3000,
  parameter int unsigned PULSE_WIDTH  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic pulse_win,
  output logic period_end
);

  localparam int unsigned CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic [31:0]   cnt_ext;

  assign cnt_ext = 32'(cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || period_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Compare against the 32-bit value so OFFSET+WIDTH == BIT_PERIOD never overflows CW bits
  assign period_end = en && (cnt_ext == BIT_PERIOD - 1);
  assign pulse_win  = en && (cnt_ext >= PULSE_OFFSET) &&
                      (cnt_ext < PULSE_OFFSET + PULSE_WIDTH);

endmodule

// File: rtl/rf_pkt_tx.sv
// OOK packet transmitter: byte loader, sync-field check and MSB-first
// serialiser with one fixed-offset pulse per '1' bit.
module rf_pkt_tx
  import rf_pkt_pkg::*;
#(
  parameter int unsigned BIT_PERIOD   = 10000,
  parameter int unsigned PULSE_OFFSET = 3000,
  parameter int unsigned PULSE_WIDTH  = 1
) (
  input  logic       i_PCLK,
  input  logic       i_PRESETn,
  input  logic       i_load_valid,
  input  logic [7:0] i_load_data,
  output logic       o_load_ready,
  input  logic       i_start,
  input  logic       i_abort,
  output logic       o_busy,
  output logic       o_pkt_full,
  output logic       o_done,
  output logic       o_err,
  output logic       o_rf_out,
  output logic [5:0] o_bit_idx
);

  state_t      state;
  logic [3:0]  byte_cnt;
  logic [63:0] pkt;
  logic [5:0]  bit_idx;
  logic        pulse_win;
  logic        period_end;
  logic        full;

  assign full         = (byte_cnt == 4'(PKT_BYTES));
  assign o_pkt_full   = full;
  assign o_load_ready = (state == IDLE) && !full;
  assign o_busy       = (state == SEND);
  assign o_bit_idx    = bit_idx;

  rf_bit_timer #(
    .BIT_PERIOD  (BIT_PERIOD),
    .PULSE_OFFSET(PULSE_OFFSET),
    .PULSE_WIDTH (PULSE_WIDTH)
  ) u_timer (
    .clk       (i_PCLK),
    .rst_n     (i_PRESETn),
    .en        (state == SEND),
    .pulse_win (pulse_win),
    .period_end(period_end)
  );

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state    <= IDLE;
      byte_cnt <= '0;
      pkt      <= '0;
      bit_idx  <= 6'd63;
      o_rf_out <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_rf_out <= 1'b0;
      o_done   <= 1'b0;
      o_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (i_abort) begin
            byte_cnt <= '0;
          end else begin
            // Start sees the count before this cycle's byte lands
            if (i_start) begin
              if (full && sync_ok(pkt)) begin
                state   <= SEND;
                bit_idx <= 6'd63;
              end else begin
                o_err <= 1'b1;
              end
            end
            if (i_load_valid && o_load_ready) begin
              pkt      <= {pkt[55:0], i_load_data};
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        SEND: begin
          if (i_abort) begin
            state    <= IDLE;
            byte_cnt <= '0;
            bit_idx  <= 6'd63;
          end else begin
            o_rf_out <= pulse_win && pkt[bit_idx];
            if (period_end) begin
              if (bit_idx == 6'd0) begin
                state  <= DONE;
                o_done <= 1'b1;
              end else begin
                bit_idx <= bit_idx - 6'd1;
              end
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          byte_cnt <= '0;
          bit_idx  <= 6'd63;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_pkt_tx.sv
// Randomized bench for rf_pkt_tx against a cycle-indexed behavioural model.
module tb_rf_pkt_tx;

  localparam int BP    = 20;
  localparam int PO    = 6;
  localparam int PW    = 2;
  localparam int NBITS = 64;

  logic       i_PCLK       = 1'b0;
  logic       i_PRESETn    = 1'b1;
  logic       i_load_valid = 1'b0;
  logic [7:0] i_load_data  = 8'h00;
  logic       i_start      = 1'b0;
  logic       i_abort      = 1'b0;
  logic       o_load_ready;
  logic       o_busy;
  logic       o_pkt_full;
  logic       o_done;
  logic       o_err;
  logic       o_rf_out;
  logic [5:0] o_bit_idx;

  int          vectors     = 0;
  int          miscompares = 0;
  int          m_cnt       = 0;
  logic [63:0] m_pkt       = '0;

  rf_pkt_tx #(
    .BIT_PERIOD  (BP),
    .PULSE_OFFSET(PO),
    .PULSE_WIDTH (PW)
  ) dut (
    .i_PCLK      (i_PCLK),
    .i_PRESETn   (i_PRESETn),
    .i_load_valid(i_load_valid),
    .i_load_data (i_load_data),
    .o_load_ready(o_load_ready),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .o_busy      (o_busy),
    .o_pkt_full  (o_pkt_full),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_rf_out    (o_rf_out),
    .o_bit_idx   (o_bit_idx)
  );

  always #5 i_PCLK = ~i_PCLK;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_PCLK);
    #1;
  endtask

  function automatic bit sync_ref(input logic [63:0] p);
    return (p[62:58] == 5'b11111) && (p[36:32] == 5'b11111);
  endfunction

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_load_ready"}, o_load_ready, 1);
    check_eq({tag, "_bit_idx"}, o_bit_idx, 63);
    check_eq({tag, "_busy"}, o_busy, 0);
    check_eq({tag, "_pkt_full"}, o_pkt_full, 0);
    check_eq({tag, "_done"}, o_done, 0);
    check_eq({tag, "_err"}, o_err, 0);
    check_eq({tag, "_rf_out"}, o_rf_out, 0);
  endtask

  // One cycle of host activity while idle; the model predicts start/load outcome
  task automatic idle_step(input logic v, input logic [7:0] d, input logic s,
                           input logic a, output bit pass);
    bit exp_err;
    pass    = 0;
    exp_err = 0;
    if (a) begin
      m_cnt = 0;
    end else begin
      pass    = s && (m_cnt == 8) && sync_ref(m_pkt);
      exp_err = s && !pass;
      if (v && m_cnt < 8) begin
        m_pkt = {m_pkt[55:0], d};
        m_cnt++;
      end
    end
    i_load_valid = v;
    i_load_data  = d;
    i_start      = s;
    i_abort      = a;
    tick();
    i_load_valid = 0;
    i_start      = 0;
    i_abort      = 0;
    check_eq("err", o_err, exp_err);
    check_eq("busy_after_step", o_busy, pass);
    check_eq("load_ready", o_load_ready, !pass && (m_cnt < 8));
    check_eq("pkt_full", o_pkt_full, m_cnt == 8);
    check_eq("done_idle", o_done, 0);
  endtask

  task automatic load_bytes(input logic [63:0] p, input int n);
    bit pass;
    for (int i = 0; i < n; i++) idle_step(1, p[63-8*i -: 8], 0, 0, pass);
  endtask

  // Cycle k counts edges after the start edge; rf_out at k reflects period position k-1
  task automatic send_check(input int abort_k, input bit spacing);
    int   pulses;
    int   last_rise;
    logic prev;
    logic exp_rf;
    pulses    = 0;
    last_rise = -1;
    prev      = 0;
    check_eq("bit_idx_start", o_bit_idx, 63);
    check_eq("rf_out_start", o_rf_out, 0);
    for (int k = 1; k <= NBITS*BP; k++) begin
      if (k - 1 == abort_k) i_abort = 1;
      tick();
      i_abort = 0;
      if (k - 1 == abort_k) begin
        m_cnt = 0;
        check_eq("abort_rf_out", o_rf_out, 0);
        check_eq("abort_busy", o_busy, 0);
        check_eq("abort_pkt_full", o_pkt_full, 0);
        check_eq("abort_done", o_done, 0);
        check_eq("abort_load_ready", o_load_ready, 1);
        repeat (3) begin
          tick();
          check_eq("abort_no_done", o_done, 0);
          check_eq("abort_rf_idle", o_rf_out, 0);
        end
        return;
      end
      exp_rf = m_pkt[NBITS-1-(k-1)/BP] && ((k-1) % BP >= PO) && ((k-1) % BP < PO + PW);
      check_eq("rf_out", o_rf_out, exp_rf);
      if (k < NBITS*BP) begin
        check_eq("busy_send", o_busy, 1);
        check_eq("done_early", o_done, 0);
        check_eq("bit_idx", o_bit_idx, 63 - k/BP);
      end else begin
        check_eq("done_pulse", o_done, 1);
        check_eq("busy_done", o_busy, 0);
        check_eq("err_done", o_err, 0);
      end
      if (o_rf_out && !prev) begin
        pulses++;
        if (spacing && last_rise >= 0) check_eq("pulse_spacing", k - last_rise, BP);
        last_rise = k;
      end
      prev = o_rf_out;
    end
    check_eq("pulse_count", pulses, $countones(m_pkt));
    tick();
    m_cnt = 0;
    check_eq("done_one_cycle", o_done, 0);
    check_eq("pkt_full_cleared", o_pkt_full, 0);
    check_eq("load_ready_after", o_load_ready, 1);
  endtask

  initial begin
    bit          pass;
    logic [63:0] p;
    int          n;
    int          ak;

    #1 i_PRESETn = 0;
    #1 check_reset_outs("rst_async");
    repeat (2) tick();
    check_reset_outs("rst_held");
    @(negedge i_PCLK);
    i_PRESETn = 1;
    tick();
    check_reset_outs("rst_release");

    // Sync fields missing: start rejected
    load_bytes(64'h8123_4567_89AB_CD0F, 8);
    idle_step(0, 8'h00, 1, 0, pass);
    idle_step(0, 8'h00, 0, 1, pass);

    // Early start after 5 bytes, then complete, overfeed a 9th byte and send
    load_bytes(64'hFC23_45FF_89AB_CD0F, 5);
    idle_step(0, 8'h00, 1, 0, pass);
    idle_step(1, 8'h89, 0, 0, pass);
    idle_step(1, 8'hAB, 0, 0, pass);
    idle_step(1, 8'hCD, 0, 0, pass);
    idle_step(1, 8'h0F, 0, 0, pass);
    idle_step(1, 8'($urandom), 0, 0, pass);
    idle_step(0, 8'h00, 1, 0, pass);
    if (pass) send_check(-1, 0);

    // Abort during bit 40, counter 7, with a '1' in bit 40
    p = {$urandom, $urandom};
    p[62:58] = '1;
    p[36:32] = '1;
    p[40]    = 1'b1;
    load_bytes(p, 8);
    idle_step(0, 8'h00, 1, 0, pass);
    if (pass) send_check((63 - 40) * BP + 7, 0);

    // Start alongside the 8th byte is rejected; next-cycle start sends all ones
    load_bytes(64'hFFFF_FFFF_FFFF_FFFF, 7);
    idle_step(1, 8'hFF, 1, 0, pass);
    idle_step(0, 8'h00, 1, 0, pass);
    if (pass) send_check(-1, 1);

    // Asynchronous reset while the first pulse is high
    load_bytes(64'hFC23_45FF_89AB_CD0F, 8);
    idle_step(0, 8'h00, 1, 0, pass);
    repeat (PO + 1) tick();
    check_eq("rf_before_reset", o_rf_out, 1);
    #2 i_PRESETn = 0;
    #1 check_reset_outs("rst_mid_send");
    m_cnt = 0;
    m_pkt = '0;
    @(negedge i_PCLK);
    i_PRESETn = 1;
    tick();
    check_reset_outs("rst_after_send");

    // Randomized packets, byte counts and aborts
    for (int it = 0; it < 4; it++) begin
      idle_step(0, 8'h00, 0, 1, pass);
      p = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) begin
        p[62:58] = '1;
        p[36:32] = '1;
      end
      n = $urandom_range(5, 9);
      load_bytes(p, (n > 8) ? 8 : n);
      if (n > 8) idle_step(1, 8'($urandom), 0, 0, pass);
      idle_step(0, 8'h00, 1, 0, pass);
      if (pass) begin
        ak = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NBITS*BP - 1)) : -1;
        send_check(ak, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
